// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   N-channel arbiter between cache/DMA requesters and one main-memory port.
//   Fixed-priority (lowest index) or round-robin selection. A killed owner is
//   drained: the memory request stays up until memory acks or the drain
//   timeout expires. The memory-side request, address, data and write enable
//   are registered.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   ch_req_i      per-channel request level, held until ack or kill
//   ch_kill_i     per-channel kill of an outstanding request
//   ch_w_en_i     per-channel write enable
//   ch_addr_i     packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata_i    packed channel write data, channel i at [i*DATA_W +: DATA_W]
//   ch_ack_o      one-cycle ack to the owning channel
//   ch_rdata_o    read data, valid with ch_ack_o, else 0
//   grant_o       one-hot current owner, 0 when idle
//   mem_req_o     registered memory request
//   mem_w_en_o    registered write enable
//   mem_addr_o    registered address
//   mem_wdata_o   registered write data
//   mem_ack_i     memory completion pulse
//   mem_rdata_i   memory read data, valid with mem_ack_i
//   timeout_o     one-cycle pulse when a drain is abandoned on timeout
module mem_arbiter_rr #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 239
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_kill_i,
  input  logic [NUM_CH-1:0]        ch_w_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_ack_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [NUM_CH-1:0]        grant_o,
  output logic                     mem_req_o,
  output logic                     mem_w_en_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     timeout_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_owner, w_owner_next;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [7:0]        r_cnt, w_cnt_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_w_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_owner_oh;
  logic [IDX_W-1:0]  w_win_idx;
  logic [IDX_W-1:0]  w_cand;
  logic              w_win_found;
  logic              w_load;
  logic              w_ack_ok;
  logic              w_timeout;

  // A request already being killed is never a candidate.
  assign w_valid = ch_req_i & ~ch_kill_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_owner_oh
      assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
    end
  endgenerate

  // Winner search: scan NUM_CH candidates starting at rr_ptr (round-robin)
  // or at 0 (fixed priority); the first valid one wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_CH);
      end else begin
        w_cand = IDX_W'(k);
      end
      if (!w_win_found && w_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_rr_ptr_next  = r_rr_ptr;
    w_cnt_next     = r_cnt;
    w_mem_req_next = r_mem_req;
    w_load         = 1'b0;
    w_ack_ok       = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A late ack from an abandoned drain lands here and is ignored.
        if (w_win_found) begin
          w_state_next   = S_BUSY;
          w_owner_next   = w_win_idx;
          w_rr_ptr_next  = IDX_W'((int'(w_win_idx) + 1) % NUM_CH);
          w_mem_req_next = 1'b1;
          w_load         = 1'b1;
        end
      end
      S_BUSY: begin
        // Kill wins over a coincident ack: the owner no longer wants data.
        if (ch_kill_i[r_owner]) begin
          if (mem_ack_i) begin
            w_mem_req_next = 1'b0;
            w_state_next   = S_IDLE;
          end else begin
            w_cnt_next   = 8'd0;
            w_state_next = S_DRAIN;
          end
        end else if (mem_ack_i) begin
          w_ack_ok       = 1'b1;
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Memory is not aborted; wait for its ack or give up after TIMEOUT.
        if (mem_ack_i) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout      = 1'b1;
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_cnt     <= w_cnt_next;
      r_mem_req <= w_mem_req_next;
      if (w_load) begin
        r_mem_w_en  <= ch_w_en_i[w_win_idx];
        r_mem_addr  <= ch_addr_i[w_win_idx*ADDR_W +: ADDR_W];
        r_mem_wdata <= ch_wdata_i[w_win_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_o     = (r_state != S_IDLE) ? w_owner_oh : '0;
  assign ch_ack_o    = w_ack_ok ? w_owner_oh : '0;
  assign ch_rdata_o  = w_ack_ok ? mem_rdata_i : '0;
  assign timeout_o   = w_timeout;
  assign mem_req_o   = r_mem_req;
  assign mem_w_en_o  = r_mem_w_en;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-channel arbiter between cache/DMA requesters and a single main-memory port.
- Generalises the two-way dcache/icache memory arbitration to NUM_CH channels.
- Adds fixed-priority or round-robin selection, per-channel kill with drain, a programmable drain timeout and registered memory-side outputs.
- Sits between the cache tops and main_mem / the DDR interface.

Parameters:
- NUM_CH, 2, number of requesting channels (index 0 = highest fixed priority); 2..8.
- ADDR_W, 32, memory address width.
- DATA_W, 128, cache-line data width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 239, drain cycles before a killed transfer is abandoned; 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req_i  in  NUM_CH  per-channel request level, held until ack or kill
- ch_kill_i  in  NUM_CH  per-channel kill of an outstanding request
- ch_w_en_i  in  NUM_CH  per-channel write enable
- ch_addr_i  in  NUM_CH*ADDR_W  channel addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata_i  in  NUM_CH*DATA_W  channel write data, packed the same way
- ch_ack_o  out  NUM_CH  one-cycle ack to the owning channel
- ch_rdata_o  out  DATA_W  read data, valid with ch_ack_o, else 0
- grant_o  out  NUM_CH  one-hot current owner, 0 when idle
- mem_req_o  out  1  registered memory request
- mem_w_en_o  out  1  registered write enable
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_ack_i  in  1  memory completion pulse
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- timeout_o  out  1  one-cycle pulse when a drain is abandoned on timeout

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state IDLE, all outputs 0, rr_ptr 0, drain counter 0. Reset mid-transfer abandons it immediately; no ack is issued.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - If any ch_req_i bit is set and that channel's ch_kill_i is low, select a winner.
  - RR_MODE=0: lowest set index wins.
  - RR_MODE=1: first set index at or after rr_ptr, wrapping modulo NUM_CH.
  - On the selection edge: latch owner; register the winner's addr/wdata/w_en onto mem_*_o; set mem_req_o=1; set rr_ptr=(owner+1) mod NUM_CH; go to BUSY.
  - With no valid request, stay in IDLE.
- BUSY: grant_o=onehot(owner); mem_req_o and mem_*_o held stable.
  - ch_kill_i[owner]=1 with mem_ack_i=1 in the same cycle: no ack, clear mem_req_o, go to IDLE.
  - ch_kill_i[owner]=1 with mem_ack_i=0: go to DRAIN, counter cleared to 0.
  - Otherwise mem_ack_i=1: same cycle (combinational), ch_ack_o[owner]=1 and ch_rdata_o=mem_rdata_i; clear mem_req_o; go to IDLE.
  - Kill takes precedence over ack.
  - Kills and requests on non-owner channels are ignored; a new request waits until IDLE.
- DRAIN: mem_req_o stays asserted (memory is not aborted); grant_o keeps the owner.
  - mem_ack_i=1: discard data, no ch_ack_o, clear mem_req_o, go to IDLE.
  - Else if counter==TIMEOUT-1: pulse timeout_o, clear mem_req_o, go to IDLE.
  - Else increment counter (8-bit, never wraps because TIMEOUT<=255).
  - A late mem_ack_i received in IDLE is ignored.
- Latency:
  - Grant edge to mem_req_o high: 0 cycles (same edge).
  - mem_ack_i to ch_ack_o: 0 cycles.
  - Minimum 1 IDLE cycle between transactions, so back-to-back throughput is one transfer per (mem latency + 1) cycles.
- ch_ack_o is at most one-hot and is never asserted outside BUSY.

Test Plan:
- RR_MODE=1, NUM_CH=3, all channels request continuously, memory acks 2 cycles after req -> grants in order 0,1,2,0; each ch_ack_o pulse is exactly one cycle.
- RR_MODE=0, ch0 and ch1 request continuously -> ch0 is granted every transaction and ch1 starves.
- ch1 read at addr 0x8000_0040, mem_rdata_i=0xDEADBEEF..., ack after 5 cycles -> mem_addr_o=0x8000_0040 with mem_w_en_o=0; ch_ack_o=3'b010 and ch_rdata_o=mem_rdata_i on the ack cycle.
- Owner kill 2 cycles after grant, mem_ack_i 4 cycles later -> state DRAIN, mem_req_o stays 1, no ch_ack_o, IDLE after the ack, timeout_o=0.
- TIMEOUT=16, kill with no mem_ack_i ever -> timeout_o pulses on the 16th DRAIN cycle, mem_req_o drops, next request is granted.
- Kill and mem_ack_i in the same cycle; separately, rst_n asserted in BUSY -> no ch_ack_o in the first case; in the second, all outputs are 0 asynchronously and arbitration restarts with rr_ptr=0.
